uart_tx_fifo: RTL and testbench

Serial output stage that sits directly downstream of the `riscv64` core. It accepts bytes from the core over a valid/ready handshake, buffers them in a small FIFO, and shifts each byte out on a single `tx` line as 8N1 UART frames at a fixed baud rate. It replaces direct LED/debug observation of core data with an on-board serial link, for example to a host terminal receiving 'H' (0x48).

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo_if.sv | 21 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_tx_fifo.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types, constants and helpers.
// Used by the TX path today and by a future RX path.
package uart_pkg;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    function automatic int calc_div(
        input int clk_hz,
        input int baud
    );
        int d;
        d = clk_hz / baud;
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte write handshake into the UART transmitter.
// The core side is master, the transmitter is slave.
interface uart_tx_fifo_if;

    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;

    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; full/empty derived from occupancy.
// Overflowing pushes and underflowing pops are ignored.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, 8N1 frames at CLK_HZ/BAUD.
// Define UART_TX_PARITY_EN for 8E1 frames with an even-parity bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int CLK_HZ     = 50_000_000,
    parameter  int BAUD       = 115200,
    parameter  int FIFO_DEPTH = 4,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave wr,
    output logic          tx,
    output logic          busy,
    output logic [CW-1:0] fifo_count
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    uart_state_e state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    head;
    logic          baud_end;
    logic          frame_slot;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr.wr_valid),
        .wdata (wr.wr_data),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign wr.wr_ready = !full;
    assign tx          = tx_q;
    assign busy        = (state_q != IDLE) || !empty;
    assign baud_end    = (baud_q == BAUD_LAST);

    // Idle, or the last clock of a stop bit: a queued byte may start here.
    assign frame_slot  = (state_q == IDLE)
                      || ((state_q == STOP) && baud_end);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                tx_d = UART_IDLE_LEVEL;
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (!baud_end) begin
                    baud_d = baud_q + BW'(1);
                end else if (bit_q == 3'd7) begin
                    baud_d  = '0;
`ifdef UART_TX_PARITY_EN
                    tx_d    = par_q;
                    state_d = PARITY;
`else
                    tx_d    = UART_IDLE_LEVEL;
                    state_d = STOP;
`endif
                end else begin
                    baud_d  = '0;
                    bit_d   = bit_q + 3'd1;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    tx_d    = shreg_q[1];
                end
            end
            PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = UART_IDLE_LEVEL;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = UART_IDLE_LEVEL;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                tx_d    = UART_IDLE_LEVEL;
                state_d = IDLE;
            end
        endcase

        if (frame_slot && !empty) begin
            pop     = 1'b1;
            shreg_d = head;
            tx_d    = 1'b0;
            baud_d  = '0;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=10 plus a DIV=1 instance.
// Frame model: start 0, data LSB first, [even parity], stop 1.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx, busy;
    logic       tx_f, busy_f;
    logic [2:0] cnt, cnt_f;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q[$];
    logic [7:0] seq[8];
    logic [7:0] rb;
    logic       rok;
    logic       done;
    int         mx;
    logic [10:0] got_v, exp_v;

    uart_tx_fifo_if wr_if ();
    uart_tx_fifo_if f_if ();

    uart_tx_fifo #(
        .CLK_HZ     (1000),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr_if),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (cnt)
    );

    uart_tx_fifo #(
        .CLK_HZ     (100),
        .BAUD       (200),
        .FIFO_DEPTH (4)
    ) u_fast (
        .clk        (clk),
        .reset      (reset),
        .wr         (f_if),
        .tx         (tx_f),
        .busy       (busy_f),
        .fifo_count (cnt_f)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic fbit(
        input logic [7:0] b,
        input int         idx
    );
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (FL == 11 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] b);
        wr_if.wr_data  = b;
        wr_if.wr_valid = 1'b1;
        tick();
        wr_if.wr_valid = 1'b0;
    endtask

    // Caller sits just after the edge where tx should first be low.
    task automatic stream(input string tag);
        int bad;
        for (int f = 0; f < q.size(); f++) begin
            bad = 0;
            for (int k = 0; k < FL * DIV; k++) begin
                if (tx !== fbit(q[f], k / DIV)) bad++;
                tick();
            end
            check($sformatf("%s_f%0d_bad", tag, f), bad, 0);
        end
    endtask

    task automatic rx_byte(
        output logic [7:0] b,
        output logic       ok
    );
        int w;
        w  = 0;
        ok = 1'b1;
        b  = '0;
        while (tx !== 1'b0 && w < 3 * FL * DIV) begin
            tick();
            w++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (DIV / 2) tick();
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) tick();
            b[i] = tx;
        end
        if (FL == 11) begin
            repeat (DIV) tick();
            if (tx !== ^b) ok = 1'b0;
        end
        repeat (DIV) tick();
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        f_if.wr_valid  = 1'b0;
        f_if.wr_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_cnt", cnt, 0);
        check("rst_ready", wr_if.wr_ready, 1);
        check("rst_fast_tx", tx_f, 1);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // single 0x48: tx low on edges 2..11, busy low at 102
        push(8'h48);
        check("s_e1_tx", tx, 1);
        check("s_e1_cnt", cnt, 1);
        check("s_e1_busy", busy, 1);
        tick();
        q.delete();
        q.push_back(8'h48);
        stream("single");
        check("s_end_busy", busy, 0);
        check("s_end_tx", tx, 1);

        // back-to-back 0x41..0x45 then a dropped 0x46
        wr_if.wr_data  = 8'h41;
        wr_if.wr_valid = 1'b1;
        tick();
        q.delete();
        for (int i = 0; i < 5; i++) q.push_back(8'h41 + 8'(i));
        fork
            begin
                for (int i = 1; i < 5; i++) begin
                    wr_if.wr_data = 8'h41 + 8'(i);
                    tick();
                end
                check("b_cnt_full", cnt, 4);
                check("b_ready_low", wr_if.wr_ready, 0);
                wr_if.wr_data = 8'h46;
                tick();
                wr_if.wr_valid = 1'b0;
                check("b_drop_cnt", cnt, 4);
            end
            begin
                tick();
                stream("b2b");
            end
        join
        check("b_end_busy", busy, 0);
        check("b_end_cnt", cnt, 0);

        // continuous valid: order kept, occupancy bounded
        seq = '{8'hC3, 8'h5A, 8'h00, 8'hFF,
                8'h81, 8'h7E, 8'h12, 8'hED};
        done = 1'b0;
        mx   = 0;
        fork
            begin
                int  i;
                logic acc;
                i = 0;
                while (i < 8) begin
                    wr_if.wr_data  = seq[i];
                    wr_if.wr_valid = 1'b1;
                    @(negedge clk);
                    acc = wr_if.wr_ready;
                    tick();
                    if (acc) i++;
                end
                wr_if.wr_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    rx_byte(rb, rok);
                    check($sformatf("p_ok%0d", i), rok, 1);
                    check($sformatf("p_byte%0d", i), rb, seq[i]);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    if (int'(cnt) > mx) mx = int'(cnt);
                    tick();
                end
            end
        join
        check("p_max_cnt", mx, 4);
        repeat (DIV) tick();
        check("p_end_busy", busy, 0);

        // reset during data bit 3 of 0x55, 0x66 queued
        push(8'h55);
        push(8'h66);
        repeat (44) tick();
        check("r_pre_tx", tx, 0);
        check("r_pre_cnt", cnt, 1);
        #2;
        reset = 1'b1;
        #1;
        check("r_tx", tx, 1);
        check("r_cnt", cnt, 0);
        check("r_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        push(8'hA5);
        check("r_a5_e1_tx", tx, 1);
        tick();
        q.delete();
        q.push_back(8'hA5);
        stream("post_rst");
        check("r_end_busy", busy, 0);

        // 0x48 then 0x07: parity bits 0 and 1 in 8E1
        push(8'h48);
        push(8'h07);
        check("par_cnt", cnt, 1);
        q.delete();
        q.push_back(8'h48);
        q.push_back(8'h07);
        stream("par");
        check("par_end_busy", busy, 0);

        // DIV floor instance: one clock per bit
        f_if.wr_data  = 8'h3C;
        f_if.wr_valid = 1'b1;
        tick();
        f_if.wr_valid = 1'b0;
        check("f_e1_tx", tx_f, 1);
        tick();
        got_v = '1;
        exp_v = '1;
        for (int k = 0; k < FL; k++) begin
            got_v[k] = tx_f;
            exp_v[k] = fbit(8'h3C, k);
            tick();
        end
        check("f_frame", got_v, exp_v);
        check("f_end_busy", busy_f, 0);

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
